// File: rtl/int_ctrl_if.sv
// Register request/response port of int_ctrl.
// valid/ready: a beat transfers on a cycle where valid and ready are both high;
// the sender holds valid and its payload stable until that cycle.
interface int_ctrl_if #(
    parameter int ADDR_W = 2
);
    logic              reg_valid;
    logic              reg_ready;
    logic [1:0]        reg_op;
    logic [ADDR_W-1:0] reg_addr;
    logic [15:0]       reg_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [15:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output reg_valid, reg_op, reg_addr, reg_wdata, rsp_ready,
        input  reg_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  reg_valid, reg_op, reg_addr, reg_wdata, rsp_ready,
        output reg_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/int_ctrl.sv
// Local interrupt controller: per-source edge/level pending, enable, highest-index priority, CSR-style register port.
// Optional macro INT_CTRL_SYNC_EN adds a 2-flop synchroniser on irq_in.
module int_ctrl #(
    parameter int          NUM_SRC  = 16,
    parameter logic [15:0] MODE_RST = 16'h0888,
    parameter int          ADDR_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               gie,
    output logic [15:0]        int_ip,
    output logic               int_req,
    output logic [3:0]         int_id,
    input  logic               int_ack,
    input  logic [3:0]         int_ack_id,
    int_ctrl_if.slave          bus,
    output logic               dbg_state_o
);
    localparam logic [15:0] SRC_MASK = 16'((17'd1 << NUM_SRC) - 17'd1);
    localparam logic [1:0] OP_RD = 2'd0, OP_RW = 2'd1, OP_RS = 2'd2, OP_RC = 2'd3;
    localparam logic [ADDR_W-1:0] A_IP = ADDR_W'(0), A_IE = ADDR_W'(1),
                                  A_MODE = ADDR_W'(2), A_ID = ADDR_W'(3);

    typedef enum logic {S_IDLE = 1'b0, S_RESP = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [15:0] ip_q, ip_d, ie_q, ie_d, mode_q, mode_d, irq_last_q;
    logic [15:0] int_ip_q;
    logic        int_req_q;
    logic [3:0]  int_id_q;
    logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;
    logic [15:0] irq_s, rise, ack_hit, act, old_val, new_val, edge_val;
    logic [3:0]  sel;
    logic        accept, bad_wr, wr_any;

`ifdef INT_CTRL_SYNC_EN
    logic [15:0] sync1_q, sync2_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= 16'(irq_in) & SRC_MASK;
            sync2_q <= sync1_q;
        end
    end
    assign irq_s = sync2_q;
`else
    assign irq_s = 16'(irq_in) & SRC_MASK;
`endif

    // Read-before-write value and the operand-combined new value
    always_comb begin
        old_val = '0;
        case (bus.reg_addr)
            A_IP:    old_val = ip_q;
            A_IE:    old_val = ie_q;
            A_MODE:  old_val = mode_q;
            default: old_val = {12'd0, int_id_q};
        endcase
        new_val = old_val;
        case (bus.reg_op)
            OP_RW:   new_val = bus.reg_wdata;
            OP_RS:   new_val = old_val | bus.reg_wdata;
            OP_RC:   new_val = old_val & ~bus.reg_wdata;
            default: new_val = old_val;
        endcase
    end

    assign bad_wr = (bus.reg_addr == A_ID) && (bus.reg_op != OP_RD);

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        accept      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.reg_valid) begin
                    accept      = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = old_val;
                    rsp_err_d   = bad_wr;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
        endcase
    end

    assign wr_any = accept && (bus.reg_op != OP_RD) && !bad_wr;

    // Edge bits: write/ack first, then a rising edge overrides; level bits follow the line
    always_comb begin
        ack_hit = '0;
        if (int_ack && ({28'd0, int_ack_id} < 32'(NUM_SRC))) begin
            ack_hit[int_ack_id] = 1'b1;
        end
        rise     = irq_s & ~irq_last_q;
        edge_val = (wr_any && bus.reg_addr == A_IP) ? new_val : (ip_q & ~ack_hit);
        ip_d     = ((mode_q & (edge_val | rise)) | (~mode_q & irq_s)) & SRC_MASK;
        ie_d     = (wr_any && bus.reg_addr == A_IE) ? (new_val & SRC_MASK) : ie_q;
        mode_d   = (wr_any && bus.reg_addr == A_MODE) ? (new_val & SRC_MASK) : mode_q;
    end

    always_comb begin
        act = ip_q & ie_q;
        sel = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (act[i]) sel = 4'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ip_q        <= '0;
            ie_q        <= '0;
            mode_q      <= MODE_RST & SRC_MASK;
            irq_last_q  <= '0;
            int_ip_q    <= '0;
            int_req_q   <= 1'b0;
            int_id_q    <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ip_q        <= ip_d;
            ie_q        <= ie_d;
            mode_q      <= mode_d;
            irq_last_q  <= irq_s;
            int_ip_q    <= act;
            int_req_q   <= gie & (|act);
            int_id_q    <= sel;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign int_ip        = int_ip_q;
    assign int_req       = int_req_q;
    assign int_id        = int_id_q;
    assign bus.reg_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign dbg_state_o   = state_q;
endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
Parametrised local interrupt controller that sits between external interrupt lines and the trap unit. It generalises the fixed software, timer and external edge detection to NUM_SRC sources. Each source has a programmable edge or level mode, an enable bit and a sticky pending bit. The block picks the highest-priority request and exposes a register port with a valid/ready request and response handshake.

Parameters:
NUM_SRC, 16, number of interrupt sources, legal range 1..16; bits at or above NUM_SRC read 0 and ignore writes
MODE_RST, 16'h0888, reset value of the MODE register (1 = edge, 0 = level); default makes sources 3, 7 and 11 edge-triggered
ADDR_W, 2, register address width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
irq_in  in  NUM_SRC  raw interrupt lines
gie  in  1  global enable from the trap unit; gates int_req
int_ip  out  16  pending & enabled vector, zero-extended, not gated by gie
int_req  out  1  an interrupt is requested
int_id  out  4  index of the selected source
int_ack  in  1  trap unit accepted int_id
int_ack_id  in  4  id being acknowledged
reg_valid  in  1  register request valid
reg_ready  out  1  register request accepted
reg_op  in  2  RD=0, RW=1, RS=2, RC=3 (same encoding as CSR ops)
reg_addr  in  ADDR_W  0 = IP, 1 = IE, 2 = MODE, 3 = ID (read-only)
reg_wdata  in  16  write operand
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_rdata  out  16  old register value (read-before-write)
rsp_err  out  1  set when a write is attempted to the ID register

Behaviour:
- Every register resets synchronously when rst=1, including in the middle of a transaction. Reset values:
  - IP = 0, IE = 0, MODE = MODE_RST, irq_last = 0.
  - int_req = 0, int_id = 0.
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
  - FSM goes to IDLE.
- Sampling: irq_s is irq_in, or the synchronised copy when the optional feature is enabled. irq_last is registered from irq_s every cycle.
- Pending update, per bit i < NUM_SRC:
  - Edge bit (MODE[i]=1): IP[i] sets on a rising edge (irq_s[i] & ~irq_last[i]). It clears on int_ack with int_ack_id == i, or on a register write. A rising edge in the same cycle as a clear wins, so IP[i] ends at 1.
  - Level bit (MODE[i]=0): IP[i] <= irq_s[i] every cycle. Register writes and acks have no effect on it.
- Priority: among bits of IP & IE, the highest index wins.
- Outputs are registered with 1-cycle latency from IP/IE:
  - int_ip = {zero-pad, IP & IE}.
  - int_req = gie & |(IP & IE).
  - int_id = selected index, or 0 when none is set.
- int_ack when int_req=0 still clears the addressed edge bit. An ack to a level bit or an id at or above NUM_SRC is ignored.
- Register FSM, states IDLE and RESP:
  - IDLE: reg_ready = 1. On reg_valid the block captures the old value into rsp_rdata and computes the new value:
    - RW: wdata
    - RS: old | wdata
    - RC: old & ~wdata
    - RD: old (no write)
  - The new value is committed in that same cycle. rsp_valid then goes to 1 and the FSM moves to RESP.
  - RESP: reg_ready = 0. rsp_valid, rsp_rdata and rsp_err hold until rsp_ready. On rsp_ready the FSM returns to IDLE; there is no back-to-back acceptance in that cycle.
  - ID register reads {12'b0, int_id}. Any op other than RD to ID sets rsp_err = 1 with no state change.
  - A write to MODE takes effect on the next cycle. A bit switching to level mode reloads from irq_s on the following cycle.
- Register writes and hardware updates in the same cycle:
  - IE and MODE take the register write.
  - IP edge bits: a hardware rising edge overrides a register clear.

Optional Feature:
INT_CTRL_SYNC_EN
- Defined: irq_in passes through a 2-flop synchroniser (reset 0) before sampling, adding 2 cycles of latency.
- Undefined: irq_in is used directly.

Test Plan:
1. Edge mode, IE[7]=1, gie=1: pulse irq_in[7] for 1 cycle -> IP[7]=1 on the next edge; int_req=1 and int_id=7 one cycle later. int_ack with id 7 -> IP[7]=0 and int_req drops the cycle after.
2. Level mode, IE[2]=1: hold irq_in[2]=1 -> int_id=2 persists through int_ack. Release -> int_req=0 two cycles later.
3. Priority: IE=16'h0888, sources 3 and 11 pend together -> int_id=11. Ack 11 -> int_id=3. With gie=0 -> int_req=0 while int_ip=16'h0808.
4. Register port: RS on IE with 0x0080 -> rsp_rdata = old value, IE |= 0x80. Hold rsp_ready=0 for 3 cycles -> rsp_valid stays 1 and reg_ready=0 throughout. RW to ID -> rsp_err=1 and nothing changes.
5. Collision: rising edge on source 3 in the same cycle as an RC on IP clearing 0x0008 -> IP[3]=1 afterwards.
6. Reset mid-response (rst while in RESP) -> rsp_valid=0, IE=0, MODE=16'h0888 on the next cycle.
